// File: rtl/jtframe_sdram_pkg.sv
// Shared types and helpers for the SDRAM bank responder and its arbiter.
package jtframe_sdram_pkg;

    localparam int   NBANK     = 4;
    localparam logic MASK_KEEP = 1'b1;   // mask bit high means the byte is taken from din

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_WRITE
    } state_t;

    // First requesting bank at or after ptr, wrapping 3->0.
    function automatic logic [1:0] rr_next(input logic [NBANK-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_next = ptr;
        for (int i = NBANK - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/jtframe_rr_arb4.sv
// Four-way round-robin arbiter with a registered one-hot grant pulse.
module jtframe_rr_arb4 import jtframe_sdram_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic [NBANK-1:0] req,
    input  logic             en,
    output logic [NBANK-1:0] gnt,
    output logic [1:0]       sel,
    output logic             take
);

    logic [1:0] ptr;

    assign sel  = rr_next(req, ptr);
    assign take = en & (|req);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
            gnt <= '0;
        end else begin
            gnt <= '0;
            if (take) begin
                gnt[sel] <= 1'b1;
                ptr      <= sel + 2'd1;
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram_bank_resp.sv
// SDRAM-side responder for the 4-bank request/ack interface, backed by a
// synchronous memory port with fixed read latency and burst length.
module jtframe_sdram_bank_resp import jtframe_sdram_pkg::*; #(
    parameter int AW      = 22,
    parameter int DW      = 16,
    parameter int LATENCY = 3,
    parameter int BURST   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ba0_addr,
    input  logic [AW-1:0]    ba1_addr,
    input  logic [AW-1:0]    ba2_addr,
    input  logic [AW-1:0]    ba3_addr,
    input  logic [3:0]       ba_rd,
    input  logic             ba_wr,
    input  logic [DW-1:0]    ba0_din,
    input  logic [1:0]       ba0_din_m,
    input  logic             hold,
    output logic [3:0]       ba_ack,
    output logic [3:0]       ba_dst,
    output logic [3:0]       ba_dok,
    output logic [3:0]       ba_rdy,
    output logic [DW-1:0]    data_read,
    output logic [AW+1:0]    mem_addr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [DW-1:0]    mem_din,
    output logic [1:0]       mem_mask,
    input  logic [DW-1:0]    mem_dout
);

    localparam logic [3:0] LAT_LAST  = 4'(LATENCY - 2);
    localparam logic [1:0] WORD_LAST = 2'(BURST - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic [1:0]    wcnt;
    logic [1:0]    bank_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_sel;
    logic [AW-1:0] addr_nxt;
    logic [3:0]    gmask;
    logic [DW-1:0] data_q;
    logic [1:0]    sel;
    logic          take;

    jtframe_rr_arb4 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (ba_rd),
        .en   (~hold & (state == ST_IDLE)),
        .gnt  (ba_ack),
        .sel  (sel),
        .take (take)
    );

    always_comb begin
        addr_sel = ba0_addr;
        case (sel)
            2'd1:    addr_sel = ba1_addr;
            2'd2:    addr_sel = ba2_addr;
            2'd3:    addr_sel = ba3_addr;
            default: addr_sel = ba0_addr;
        endcase
    end

    // Burst offset wraps inside the bank; truncation to AW keeps the bank bits clean.
    assign addr_nxt = addr_q + AW'(wcnt) + AW'(1);
    assign gmask    = 4'b0001 << bank_q;

    // The word is driven straight from the memory port the cycle it becomes valid.
    assign data_read = (|ba_dok) ? mem_dout : data_q;

    always_ff @(posedge clk) begin
        if (rst)           data_q <= '0;
        else if (|ba_dok)  data_q <= mem_dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            wcnt     <= 2'd0;
            bank_q   <= 2'd0;
            addr_q   <= '0;
            ba_dst   <= 4'd0;
            ba_dok   <= 4'd0;
            ba_rdy   <= 4'd0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_din  <= '0;
            mem_mask <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: if (take) begin
                    bank_q <= sel;
                    cnt    <= 4'd0;
                    wcnt   <= 2'd0;
                    if (sel == 2'd0 && ba_wr) begin
                        state    <= ST_WRITE;
                        mem_wr   <= 1'b1;
                        mem_addr <= {2'd0, ba0_addr};
                        mem_din  <= ba0_din;
                        mem_mask <= MASK_KEEP ? ba0_din_m : ~ba0_din_m;
                    end else begin
                        state  <= ST_WAIT;
                        addr_q <= addr_sel;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAT_LAST) begin
                        state    <= ST_BURST;
                        mem_rd   <= 1'b1;
                        mem_addr <= {bank_q, addr_q};
                    end
                end
                // mem_rd low in BURST marks the cycle carrying the last word and rdy.
                ST_BURST: if (mem_rd) begin
                    ba_dok <= gmask;
                    ba_dst <= (wcnt == 2'd0)      ? gmask : 4'd0;
                    ba_rdy <= (wcnt == WORD_LAST) ? gmask : 4'd0;
                    if (wcnt == WORD_LAST) begin
                        mem_rd <= 1'b0;
                    end else begin
                        wcnt     <= wcnt + 2'd1;
                        mem_addr <= {bank_q, addr_nxt};
                    end
                end else begin
                    ba_dok <= 4'd0;
                    ba_dst <= 4'd0;
                    ba_rdy <= 4'd0;
                    state  <= ST_IDLE;
                end
                ST_WRITE: if (mem_wr) begin
                    mem_wr <= 1'b0;
                    ba_rdy <= 4'b0001;
                end else begin
                    ba_rdy <= 4'd0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_bank_resp.sv
// Directed bench for jtframe_sdram_bank_resp with a behavioural memory model.
module tb_jtframe_sdram_bank_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [21:0] ba0_addr = '0, ba1_addr = '0, ba2_addr = '0, ba3_addr = '0;
    logic [3:0]  ba_rd = '0;
    logic        ba_wr = 1'b0;
    logic [15:0] ba0_din = '0;
    logic [1:0]  ba0_din_m = '0;
    logic        hold = 1'b0;
    logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
    logic [15:0] data_read;
    logic [23:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_din;
    logic [1:0]  mem_mask;
    logic [15:0] mem_dout = '0;

    int checks = 0;
    int errors = 0;

    jtframe_sdram_bank_resp dut (
        .clk(clk), .rst(rst),
        .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
        .ba_rd(ba_rd), .ba_wr(ba_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m), .hold(hold),
        .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
        .data_read(data_read), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_din(mem_din), .mem_mask(mem_mask), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory: unwritten words return a fixed pattern of their full address.
    logic [15:0] mem [logic [23:0]];

    function automatic logic [15:0] init_val(input logic [23:0] a);
        return (a[15:0] ^ 16'h5A5A) + {a[23:22], 14'd0};
    endfunction

    function automatic logic [15:0] rd_mem(input logic [23:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin : mem_model
        logic [15:0] cur;
        if (mem_wr) begin
            cur = rd_mem(mem_addr);
            if (mem_mask[0]) cur[7:0]  = mem_din[7:0];
            if (mem_mask[1]) cur[15:8] = mem_din[15:8];
            mem[mem_addr] = cur;
        end
        if (mem_rd) mem_dout <= rd_mem(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({ba_ack, ba_dst, ba_dok, ba_rdy} !== 16'h0) begin
            errors++; $display("FAIL reset_status: got %h expected 0", {ba_ack, ba_dst, ba_dok, ba_rdy});
        end
        checks++;
        if ({mem_rd, mem_wr, mem_addr, data_read} !== 42'h0) begin
            errors++; $display("FAIL reset_mem: got rd=%b wr=%b addr=%h data=%h expected all 0", mem_rd, mem_wr, mem_addr, data_read);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        ba2_addr = 22'h001230;
        ba_rd = 4'b0100;
        tick();                                   // A
        checks++;
        if (ba_ack !== 4'b0100) begin errors++; $display("FAIL rd_ack: got %b expected 0100", ba_ack); end
        ba_rd = 4'b0000;
        tick();                                   // A+1
        checks++;
        if (ba_ack !== 4'b0000) begin errors++; $display("FAIL rd_ack_pulse: got %b expected 0000", ba_ack); end
        tick();                                   // A+2
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 24'h801230) begin
            errors++; $display("FAIL rd_issue: got rd=%b addr=%h expected rd=1 addr=801230", mem_rd, mem_addr);
        end
        checks++;
        if (ba_dok !== 4'b0000) begin errors++; $display("FAIL rd_early_dok: got %b expected 0000", ba_dok); end
        tick();                                   // A+3
        checks++;
        if (data_read !== init_val(24'h801230) || ba_dst !== 4'b0100 || ba_dok !== 4'b0100 || ba_rdy !== 4'b0000) begin
            errors++; $display("FAIL rd_word0: got data=%h dst=%b dok=%b rdy=%b expected data=%h dst=0100 dok=0100 rdy=0000",
                               data_read, ba_dst, ba_dok, ba_rdy, init_val(24'h801230));
        end
        tick();                                   // A+4
        checks++;
        if (data_read !== init_val(24'h801231) || ba_dst !== 4'b0000 || ba_dok !== 4'b0100 || ba_rdy !== 4'b0100) begin
            errors++; $display("FAIL rd_word1: got data=%h dst=%b dok=%b rdy=%b expected data=%h dst=0000 dok=0100 rdy=0100",
                               data_read, ba_dst, ba_dok, ba_rdy, init_val(24'h801231));
        end
        tick();                                   // A+5: bus idle, data held
        checks++;
        if (ba_dok !== 4'b0000 || ba_rdy !== 4'b0000 || data_read !== init_val(24'h801231)) begin
            errors++; $display("FAIL rd_idle_hold: got dok=%b rdy=%b data=%h expected dok=0 rdy=0 data=%h",
                               ba_dok, ba_rdy, data_read, init_val(24'h801231));
        end
        repeat (3) tick();
    endtask

    task automatic test_round_robin();
        int order[3];
        int ack_t[3];
        int rdy_t[3];
        int na = 0;
        int nr = 0;
        for (int i = 0; i < 3; i++) begin order[i] = -1; ack_t[i] = 0; rdy_t[i] = 0; end
        rst = 1'b1; tick(); rst = 1'b0;
        ba0_addr = 22'h000100; ba1_addr = 22'h000200; ba3_addr = 22'h000300;
        ba_rd = 4'b1011;
        for (int c = 0; c < 60 && nr < 3; c++) begin
            tick();
            if (ba_ack !== 4'b0000 && na < 3) begin
                for (int b = 0; b < 4; b++) if (ba_ack[b]) order[na] = b;
                ack_t[na] = c;
                na++;
                ba_rd = ba_rd & ~ba_ack;
            end
            if (ba_rdy !== 4'b0000 && nr < 3) begin rdy_t[nr] = c; nr++; end
        end
        checks++;
        if (nr != 3) begin errors++; $display("FAIL rr_timeout: got %0d rdy pulses expected 3", nr); end
        checks++;
        if (order[0] != 0 || order[1] != 1 || order[2] != 3) begin
            errors++; $display("FAIL rr_order: got %0d,%0d,%0d expected 0,1,3", order[0], order[1], order[2]);
        end
        checks++;
        if (ack_t[1] - rdy_t[0] != 2 || ack_t[2] - rdy_t[1] != 2) begin
            errors++; $display("FAIL rr_gap: got %0d,%0d expected 2,2", ack_t[1] - rdy_t[0], ack_t[2] - rdy_t[1]);
        end
        ba_rd = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic test_write();
        ba0_addr = 22'h000010; ba0_din = 16'hABCD; ba0_din_m = 2'b01;
        ba_wr = 1'b1; ba_rd = 4'b0001;
        tick();                                   // A
        checks++;
        if (ba_ack !== 4'b0001 || mem_wr !== 1'b1) begin
            errors++; $display("FAIL wr_ack: got ack=%b wr=%b expected ack=0001 wr=1", ba_ack, mem_wr);
        end
        checks++;
        if (mem_addr !== 24'h000010 || mem_din !== 16'hABCD || mem_mask !== 2'b01) begin
            errors++; $display("FAIL wr_port: got addr=%h din=%h mask=%b expected addr=000010 din=abcd mask=01", mem_addr, mem_din, mem_mask);
        end
        ba_rd = 4'b0000; ba_wr = 1'b0;
        tick();                                   // A+1
        checks++;
        if (ba_rdy !== 4'b0001 || ba_dst !== 4'b0000 || ba_dok !== 4'b0000 || mem_wr !== 1'b0) begin
            errors++; $display("FAIL wr_rdy: got rdy=%b dst=%b dok=%b wr=%b expected rdy=0001 dst=0 dok=0 wr=0", ba_rdy, ba_dst, ba_dok, mem_wr);
        end
        repeat (2) tick();
        ba_rd = 4'b0001;
        tick();
        ba_rd = 4'b0000;
        repeat (3) tick();                        // A+3
        checks++;
        if (data_read !== 16'h5ACD || ba_dst !== 4'b0001) begin
            errors++; $display("FAIL wr_readback: got data=%h dst=%b expected data=5acd dst=0001", data_read, ba_dst);
        end
        repeat (4) tick();
    endtask

    task automatic test_hold();
        int acks = 0;
        logic wr_seen = 1'b0;
        hold = 1'b1; ba_rd = 4'b0100; ba_wr = 1'b1;
        repeat (10) begin
            tick();
            if (ba_ack !== 4'b0000) acks++;
            if (mem_wr) wr_seen = 1'b1;
        end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL hold_block: got %0d acks expected 0", acks); end
        hold = 1'b0;
        tick();                                   // A
        checks++;
        if (ba_ack !== 4'b0100) begin errors++; $display("FAIL hold_release: got %b expected 0100", ba_ack); end
        if (mem_wr) wr_seen = 1'b1;
        ba_rd = 4'b0000; ba_wr = 1'b0;
        tick();                                   // A+1
        hold = 1'b1;
        tick(); tick();                           // A+3
        checks++;
        if (ba_dok !== 4'b0100 || ba_dst !== 4'b0100) begin
            errors++; $display("FAIL hold_midburst: got dok=%b dst=%b expected 0100/0100", ba_dok, ba_dst);
        end
        tick();                                   // A+4
        checks++;
        if (ba_rdy !== 4'b0100) begin errors++; $display("FAIL hold_rdy: got %b expected 0100", ba_rdy); end
        checks++;
        if (wr_seen !== 1'b0) begin errors++; $display("FAIL wr_without_rd0: got mem_wr=1 expected 0"); end
        hold = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_wrap();
        ba1_addr = 22'h3FFFFF;
        ba_rd = 4'b0010;
        tick();                                   // A
        ba_rd = 4'b0000;
        tick(); tick();                           // A+2
        checks++;
        if (mem_addr !== 24'h7FFFFF) begin errors++; $display("FAIL wrap_addr0: got %h expected 7fffff", mem_addr); end
        tick();                                   // A+3
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 24'h400000) begin
            errors++; $display("FAIL wrap_addr1: got rd=%b addr=%h expected rd=1 addr=400000", mem_rd, mem_addr);
        end
        checks++;
        if (data_read !== init_val(24'h7FFFFF)) begin
            errors++; $display("FAIL wrap_word0: got %h expected %h", data_read, init_val(24'h7FFFFF));
        end
        tick();                                   // A+4
        checks++;
        if (data_read !== init_val(24'h400000) || ba_rdy !== 4'b0010) begin
            errors++; $display("FAIL wrap_word1: got data=%h rdy=%b expected data=%h rdy=0010", data_read, ba_rdy, init_val(24'h400000));
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        logic bad = 1'b0;
        int   got = 0;
        ba3_addr = 22'h000055;
        ba_rd = 4'b1000;
        tick();                                   // A
        checks++;
        if (ba_ack !== 4'b1000) begin errors++; $display("FAIL rst_mid_ack: got %b expected 1000", ba_ack); end
        tick();                                   // A+1
        rst = 1'b1;
        tick();                                   // A+2
        checks++;
        if ({ba_ack, ba_dst, ba_dok, ba_rdy} !== 16'h0 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || data_read !== 16'h0) begin
            errors++; $display("FAIL rst_mid_outputs: got status=%h rd=%b wr=%b data=%h expected all 0",
                               {ba_ack, ba_dst, ba_dok, ba_rdy}, mem_rd, mem_wr, data_read);
        end
        rst = 1'b0;
        for (int c = 1; c <= 8 && got == 0; c++) begin
            tick();
            if ((ba_dst | ba_dok | ba_rdy) !== 4'b0000) bad = 1'b1;
            if (ba_ack === 4'b1000) got = c;
        end
        checks++;
        if (got != 1) begin errors++; $display("FAIL rst_mid_reack: got ack after %0d cycles expected 1", got); end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL rst_mid_norsp: got stray dst/dok/rdy expected none"); end
        ba_rd = 4'b0000;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_hold();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtframe_sdram_bank_resp.md
Name: jtframe_sdram_bank_resp

Overview:
Responder (SDRAM-controller side) of the 4-bank request/ack interface driven by the game-side bank muxes. It arbitrates ba_rd requests round-robin, accepts bank-0 writes, and serves them from a simple synchronous memory port. It generates ba_ack/ba_dst/ba_dok/ba_rdy and the shared data_read bus with fixed, parameterised timing. It is used as the bank back end for FPGA targets and simulation.

Parameters:
AW, 22, word address width per bank
DW, 16, data width of data_read and the memory port
LATENCY, 3, cycles from the ba_ack pulse to the first read word (legal range 2..15)
BURST, 2, words returned per read (1..4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ba0_addr  in  AW  bank 0 word address
ba1_addr  in  AW  bank 1 word address
ba2_addr  in  AW  bank 2 word address
ba3_addr  in  AW  bank 3 word address
ba_rd  in  4  per-bank request, level; held until ba_ack
ba_wr  in  1  bank 0 write qualifier; valid only together with ba_rd[0]
ba0_din  in  DW  bank 0 write data
ba0_din_m  in  2  bank 0 byte write mask, active high = byte kept
hold  in  1  blocks new grants (refresh/download window)
ba_ack  out  4  one-cycle grant pulse per bank
ba_dst  out  4  first read word valid on data_read
ba_dok  out  4  any read word valid on data_read
ba_rdy  out  4  transaction complete (last read word, or write done)
data_read  out  DW  read data, shared by all banks
mem_addr  out  AW+2  {bank[1:0], word address}
mem_rd  out  1  memory read strobe; mem_dout is valid the next cycle
mem_wr  out  1  memory write strobe
mem_din  out  DW  write data
mem_mask  out  2  byte mask, active high = byte kept
mem_dout  in  DW  read data from memory

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Reset: all outputs 0, FSM goes to IDLE, round-robin pointer set to bank 0, counters cleared. Reset asserted mid-transaction abandons it with no rdy; the requester re-requests.
- Concurrency: one transaction in flight at a time. FSM states are IDLE, WAIT, BURST, WRITE.
- IDLE:
  - With hold=0 and any ba_rd bit set, the grant is the first set bit at or after rr_ptr, wrapping 3->0.
  - Next cycle: ba_ack[g]=1 for exactly one cycle. Address, din and mask are latched at grant.
  - rr_ptr becomes g+1 mod 4 on each grant.
  - hold=1 in IDLE: no grant. hold does not affect a transaction already in flight.
- Read (g any, or g=0 with ba_wr=0):
  - Ack cycle is A. FSM enters WAIT.
  - mem_rd for word k is issued at A+LATENCY-1+k, with mem_addr = {g, base+k}. The sum is modulo 2^AW: it wraps inside the bank and never carries into the bank bits.
  - Word k appears on data_read at A+LATENCY+k with ba_dok[g]=1.
  - ba_dst[g]=1 only at k=0. ba_rdy[g]=1 only at k=BURST-1; with BURST=1, dst and rdy assert together.
  - After the last word, the FSM returns to IDLE. The earliest next grant is arbitrated the cycle after rdy, so the next ack comes 2 cycles after rdy.
- Write (g=0, ba_wr=1 at grant):
  - At ack cycle A: mem_wr=1, mem_addr={0,addr}, mem_din=ba0_din, mem_mask=ba0_din_m.
  - At A+1: ba_rdy[0]=1. ba_dst and ba_dok stay 0. FSM then returns to IDLE.
  - ba_wr without ba_rd[0] is ignored.
- Request level after ack: ba_rd still high at the cycle after rdy is a new request.
- Bus idle values: when no word is valid, data_read holds its last value and ba_dst/ba_dok/ba_rdy are 0.
- Output registration: all status outputs are registered. At most one bit of each of ba_ack, ba_dst, ba_dok and ba_rdy is high in any cycle.
- Counters: the latency counter is 4 bits and the word counter is 2 bits.

Decomposition:
- Shared package jtframe_sdram_pkg holds:
  - FSM state enum
  - bank count constant (4)
  - mask polarity constant
  - a function for round-robin next-grant
- Natural sub-module: jtframe_rr_arb4, a 4-input round-robin arbiter with pointer, enable (~hold & idle) and registered one-hot grant.

Test Plan:
- Single read, bank 2 at 0x001230, LATENCY=3, BURST=2, memory preloaded:
  - ack[2] at A.
  - At A+3: data_read = mem[{2,0x001230}], dst[2]=1, dok[2]=1.
  - At A+4: data_read = mem[{2,0x001231}], dok[2]=1, rdy[2]=1.
- Simultaneous ba_rd=4'b1011 from reset, each requester dropping its request at its own ack -> grants in order 0, 1, 3; each ack is 2 cycles after the previous rdy.
- Write bank 0, addr 0x000010, din 0xABCD, mask 2'b01 -> mem_wr with mask 01 at A, rdy[0] at A+1, dst/dok stay 0. Subsequent read of that word returns {old upper byte, 0xCD}.
- hold=1 with ba_rd=4'b0100 for 10 cycles -> no ack. Drop hold -> ack[2] the next cycle. Setting hold mid-burst does not stop the remaining words or rdy.
- Read bank 1 at 0x3FFFFF, BURST=2 -> second word is fetched from mem_addr {1,0x000000}; there is no carry into bank 2.
- rst asserted in the cycle after ack[3] -> no dst/dok/rdy for bank 3; all outputs 0. After release, with ba_rd[3] still high, ack[3] is issued again.
